// File: rtl/timer_arbiter.sv
// timer_arbiter
//   One programmable one-shot delay counter shared round-robin by NREQ
//   requesters. A grant latches the owner's delay and then counts i_en
//   ticks. At expiry the owner's done bit pulses for one cycle and the
//   arbiter picks the next requester.
//
// Ports
//   i_clk    clock
//   i_rst    asynchronous, active-high reset
//   i_en     tick enable; the count advances only when high
//   i_req    level request per requester; dropping it cancels
//   i_delay  delay for requester k in [k*WIDTH +: WIDTH], sampled at grant
//   o_grant  one-hot owner of the timer (registered)
//   o_done   one-cycle expiry pulse on the owner's bit (registered)
//   o_busy   high while counting and during the done cycle (registered)
module timer_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*WIDTH-1:0]   i_delay,
  output logic [NREQ-1:0]         o_grant,
  output logic [NREQ-1:0]         o_done,
  output logic                    o_busy
);

  localparam int          IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned N  = NREQ;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] dly_q, dly_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [NREQ-1:0]  grant_d, done_d;
  logic             busy_d;

  logic [WIDTH-1:0] delay_arr [NREQ];
  logic [IW-1:0]    pick;
  logic             found;
  logic [NREQ-1:0]  pick_oh;
  logic [NREQ-1:0]  sel_oh;

  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      delay_arr[k] = i_delay[k*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: first set request starting just after last served,
  // wrapping around so the last-served requester is considered last.
  always_comb begin : arb
    int unsigned   idx;
    logic [IW-1:0] idx_v;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    idx_v = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N) idx = idx - N;
      idx_v = idx[IW-1:0];
      if (!found && i_req[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end
    end
  end

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
    sel_oh        = '0;
    sel_oh[sel_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dly_d   = dly_q;
    last_d  = last_q;
    sel_d   = sel_q;
    grant_d = o_grant;
    done_d  = '0;
    busy_d  = o_busy;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (found) begin
          sel_d   = pick;
          dly_d   = delay_arr[pick];
          count_d = '0;
          grant_d = pick_oh;
          busy_d  = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // A dropped request cancels even if expiry would fire this cycle.
        if (!i_req[sel_q]) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          last_d  = sel_q;
        end else if (i_en) begin
          if (count_q >= dly_q) begin
            state_d = DONE;
            done_d  = sel_oh;
            grant_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        last_d  = sel_q;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      dly_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      sel_q   <= '0;
      o_grant <= '0;
      o_done  <= '0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dly_q   <= dly_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      o_grant <= grant_d;
      o_done  <= done_d;
      o_busy  <= busy_d;
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed testbench for timer_arbiter (NREQ=4, WIDTH=4 so the maximum
// delay of 15 is reachable). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_timer_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           i_clk;
  logic           i_rst;
  logic           i_en;
  logic [N-1:0]   i_req;
  logic [N*W-1:0] i_delay;
  logic [N-1:0]   o_grant;
  logic [N-1:0]   o_done;
  logic           o_busy;

  int checks = 0;
  int errors = 0;

  timer_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_req   (i_req),
    .i_delay (i_delay),
    .o_grant (o_grant),
    .o_done  (o_done),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one clock; also checks the one-hot / exclusivity invariants.
  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (!$onehot0(o_grant) || !$onehot0(o_done) || (o_grant != '0 && o_done != '0)) begin
      errors++;
      $display("FAIL invariant: grant=%b done=%b", o_grant, o_done);
    end
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_en = 1'b0; i_req = '0; i_delay = '0;
    @(negedge i_clk);
    checks++;
    if (o_grant !== 4'b0000 || o_done !== 4'b0000 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b done=%b busy=%b want 0000 0000 0", o_grant, o_done, o_busy);
    end
    i_rst = 1'b0;
    tick();
    checks++;
    if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: grant=%b busy=%b want 0000 0", o_grant, o_busy);
    end
  endtask

  task automatic test_single();
    i_delay[0*W +: W] = 4'd5;
    i_en  = 1'b1;
    i_req = 4'b0001;
    tick();
    checks++;
    if (o_grant !== 4'b0001 || o_busy !== 1'b1 || o_done !== 4'b0000) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b done=%b want 0001 1 0000", o_grant, o_busy, o_done);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (o_done !== 4'b0000 || o_grant !== 4'b0001) begin
        errors++;
        $display("FAIL single_counting cyc%0d: done=%b grant=%b want 0000 0001", i, o_done, o_grant);
      end
    end
    i_delay[0*W +: W] = 4'd9; // ignored after grant
    tick();
    checks++;
    if (o_done !== 4'b0001 || o_grant !== 4'b0000 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_done: done=%b grant=%b busy=%b want 0001 0000 1", o_done, o_grant, o_busy);
    end
    i_req = 4'b0000;
    tick();
    checks++;
    if (o_done !== 4'b0000 || o_busy !== 1'b0 || o_grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_after: done=%b busy=%b grant=%b want 0000 0 0000", o_done, o_busy, o_grant);
    end
  endtask

  task automatic test_zero_gated();
    i_delay[1*W +: W] = 4'd0;
    i_en  = 1'b0;
    i_req = 4'b0010;
    tick();
    checks++;
    if (o_grant !== 4'b0010) begin
      errors++;
      $display("FAIL zero_grant_no_en: grant=%b want 0010", o_grant);
    end
    tick();
    tick();
    checks++;
    if (o_done !== 4'b0000 || o_grant !== 4'b0010) begin
      errors++;
      $display("FAIL zero_hold: done=%b grant=%b want 0000 0010", o_done, o_grant);
    end
    i_en = 1'b1;
    tick();
    i_en = 1'b0;
    checks++;
    if (o_done !== 4'b0010) begin
      errors++;
      $display("FAIL zero_done: done=%b want 0010", o_done);
    end
    i_req = 4'b0000;
    tick();
    // delay 3 with enable one cycle in three: done after 4th enabled cycle
    i_delay[1*W +: W] = 4'd3;
    i_req = 4'b0010;
    tick();
    checks++;
    if (o_grant !== 4'b0010) begin
      errors++;
      $display("FAIL gated_grant: grant=%b want 0010", o_grant);
    end
    for (int n = 1; n <= 4; n++) begin
      i_en = 1'b0;
      tick();
      tick();
      checks++;
      if (o_done !== 4'b0000 || o_grant !== 4'b0010) begin
        errors++;
        $display("FAIL gated_frozen n%0d: done=%b grant=%b want 0000 0010", n, o_done, o_grant);
      end
      i_en = 1'b1;
      tick();
      checks++;
      if (o_done !== ((n == 4) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL gated_enabled n%0d: done=%b want %b", n, o_done, (n == 4) ? 4'b0010 : 4'b0000);
      end
    end
    i_req = 4'b0000;
    tick();
  endtask

  task automatic test_cancel();
    i_en = 1'b1;
    i_delay[2*W +: W] = 4'd10;
    i_delay[3*W +: W] = 4'd1;
    i_req = 4'b1100; // last served was 1, so 2 wins
    tick();
    checks++;
    if (o_grant !== 4'b0100) begin
      errors++;
      $display("FAIL cancel_grant: grant=%b want 0100", o_grant);
    end
    for (int i = 0; i < 4; i++) tick();
    i_req = 4'b1000;
    tick();
    checks++;
    if (o_grant !== 4'b0000 || o_busy !== 1'b0 || o_done !== 4'b0000) begin
      errors++;
      $display("FAIL cancel_idle: grant=%b busy=%b done=%b want 0000 0 0000", o_grant, o_busy, o_done);
    end
    tick();
    checks++;
    if (o_grant !== 4'b1000) begin
      errors++;
      $display("FAIL cancel_next_grant: grant=%b want 1000", o_grant);
    end
    tick();
    checks++;
    if (o_done !== 4'b0000) begin
      errors++;
      $display("FAIL pending_early: done=%b want 0000", o_done);
    end
    tick();
    checks++;
    if (o_done !== 4'b1000) begin
      errors++;
      $display("FAIL pending_done: done=%b want 1000", o_done);
    end
    i_req = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_oh;
    pulse_reset();
    for (int k = 0; k < N; k++) i_delay[k*W +: W] = 4'd2;
    i_en  = 1'b1;
    i_req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      exp_oh = 4'b0001 << (s % 4);
      tick();
      checks++;
      if (o_grant !== exp_oh) begin
        errors++;
        $display("FAIL rr_grant s%0d: grant=%b want %b", s, o_grant, exp_oh);
      end
      tick();
      tick();
      tick();
      checks++;
      if (o_done !== exp_oh || o_grant !== 4'b0000) begin
        errors++;
        $display("FAIL rr_done s%0d: done=%b grant=%b want %b 0000", s, o_done, o_grant, exp_oh);
      end
      tick();
      checks++;
      if (o_done !== 4'b0000 || o_grant !== 4'b0000 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle_gap s%0d: done=%b grant=%b busy=%b want 0000 0000 0", s, o_done, o_grant, o_busy);
      end
    end
    i_req = 4'b0000;
    tick();
  endtask

  task automatic test_max_delay();
    pulse_reset();
    i_delay[0*W +: W] = 4'd15;
    i_en  = 1'b1;
    i_req = 4'b0001;
    tick();
    checks++;
    if (o_grant !== 4'b0001) begin
      errors++;
      $display("FAIL max_grant: grant=%b want 0001", o_grant);
    end
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (o_done !== 4'b0000 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL max_early cyc%0d: done=%b busy=%b want 0000 1", i, o_done, o_busy);
      end
    end
    tick();
    checks++;
    if (o_done !== 4'b0001) begin
      errors++;
      $display("FAIL max_done: done=%b want 0001", o_done);
    end
    i_req = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    i_delay[2*W +: W] = 4'd10;
    i_en  = 1'b1;
    i_req = 4'b0100;
    tick();
    checks++;
    if (o_grant !== 4'b0100 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre_grant: grant=%b busy=%b want 0100 1", o_grant, o_busy);
    end
    tick();
    tick();
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (o_grant !== 4'b0000 || o_done !== 4'b0000 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: grant=%b done=%b busy=%b want 0000 0000 0", o_grant, o_done, o_busy);
    end
    @(negedge i_clk);
    i_req = 4'b1111;
    i_rst = 1'b0;
    tick();
    checks++;
    if (o_grant !== 4'b0001) begin
      errors++;
      $display("FAIL areset_first_grant: grant=%b want 0001", o_grant);
    end
    i_req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_gated();
    test_cancel();
    test_round_robin();
    test_max_delay();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one programmable one-shot delay counter among NREQ requesters (e.g. CPU wait instruction, UART bit-timer, debounce logic) so the design does not need a fixed-threshold counter instance per client.
- Round-robin arbitration picks a requester, latches its delay, and counts enabled ticks.
- On expiry it pulses that requester's done line, then re-arbitrates.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, delay/count width in bits.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_en  in  1  tick enable; the count advances only on cycles with i_en=1.
- i_req  in  NREQ  level request per requester; held high until o_done, dropping it cancels.
- i_delay  in  NREQ*WIDTH  delay for requester k in bits [k*WIDTH +: WIDTH]; sampled only at grant.
- o_grant  out  NREQ  one-hot, current owner of the timer.
- o_done  out  NREQ  one-cycle pulse on the owner's bit at expiry.
- o_busy  out  1  high in COUNT and DONE.

Behaviour:
- Reset (async, any state):
  - state=IDLE; count=0; latched delay=0.
  - o_grant=0, o_done=0, o_busy=0.
  - last-served pointer=NREQ-1, so requester 0 has highest priority first.
- All outputs are registered.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If any i_req bit is set, select the first set bit searching from (last+1) mod NREQ upward with wrap.
  - On the same edge: load dly=i_delay[sel], set count=0, set o_grant=onehot(sel), o_busy=1, go to COUNT.
  - If no request is set, stay in IDLE with all outputs 0.
  - Latency: request visible at edge k gives o_grant at edge k+1. i_en does not gate arbitration.
- COUNT (owner = sel):
  - If i_req[sel]=0: cancel. Go to IDLE, clear o_grant and o_busy, no o_done, set last=sel.
  - Else if i_en=1 and count>=dly: go to DONE, set o_done[sel]=1, clear o_grant.
  - Else if i_en=1: count=count+1 (never wraps, because count<dly<=2^WIDTH-1).
  - Else (i_en=0): hold.
  - Timing: delay D gives o_done high exactly D+1 enabled COUNT cycles after grant. D=0 gives o_done after 1 enabled cycle.
- DONE:
  - Lasts exactly one cycle with o_done[sel]=1 and o_busy=1.
  - Next edge: o_done=0, o_busy=0, last=sel, go to IDLE.
- Re-request: a requester that keeps i_req high after o_done is a new request. Any other pending requester wins first (round-robin). Minimum gap between successive grants is 1 IDLE cycle.
- Priority: cancel (i_req drop) beats expiry when both occur in the same cycle.
- Mid-operation changes: i_delay changes after grant are ignored. i_req changes for non-owners only affect the next arbitration.
- Invariants:
  - o_grant is one-hot or zero; o_done is one-hot or zero.
  - o_grant and o_done are never both nonzero in the same cycle.
  - count<=dly whenever in COUNT.

Test Plan:
- Single request: reset, i_en=1, i_req=4'b0001, delay0=5 -> o_grant=0001 one cycle after request; o_done[0] pulses exactly 6 cycles after grant; o_busy drops the cycle after.
- Zero delay and gated enable: delay1=0, i_req=0010, i_en toggles 1 cycle in 3 -> o_done[1] after the first i_en=1 cycle in COUNT; with delay1=3 -> done after the 4th enabled cycle, count frozen while i_en=0.
- Round-robin: i_req=1111 held, all delays=2 -> grants in order 0,1,2,3,0 with one IDLE cycle between them; each o_done pulse is 1 cycle wide.
- Cancel: delay2=10, i_req=0100 dropped 4 cycles after grant -> no o_done; IDLE next cycle; pending i_req=1000 granted one cycle later.
- Max delay: WIDTH=4, delay=15 -> o_done after 16 enabled cycles; count never exceeds 15.
- Async reset mid-COUNT: assert i_rst between edges -> outputs 0 immediately; after release with i_req=1111, requester 0 is granted first.
